lsu_mem_stage: RTL
==================

Name: lsu_mem_stage

Overview:
Memory-access stage load/store unit between instruction execute and write-back in the 5-stage RISC-V core. It replaces the fixed-latency data memory with a req/gnt/rvalid bus, so the on-board DDR3 controller can sit behind it. The unit handles byte-lane steering, load sign/zero extension and misalignment detection. It stalls the pipeline while an access is outstanding.

Parameters:
DATA_WIDTH, 32, data bus and register width (fixed at 32 for RV32)
ADDR_WIDTH, 32, byte address width

Ports:
i_clk  in  1  clock
i_reset_n  in  1  synchronous, active-low reset
i_ie_valid  in  1  execute-stage instruction valid
i_ie_rd_en  in  1  instruction is a load
i_ie_wr_en  in  1  instruction is a store
i_ie_funct3  in  3  access size/sign (RV32I LB/LH/LW/LBU/LHU, SB/SH/SW)
i_ie_addr  in  ADDR_WIDTH  byte address (ALU result)
i_ie_wr_data  in  DATA_WIDTH  store data (rs2)
o_stall  out  1  freeze IF..IE stages
o_rd_data  out  DATA_WIDTH  extended load result
o_rd_valid  out  1  one-cycle pulse, o_rd_data valid
o_fault  out  1  one-cycle pulse, misaligned address or illegal funct3
o_mem_req  out  1  bus request
i_mem_gnt  in  1  request accepted
o_mem_we  out  1  1 = write
o_mem_addr  out  ADDR_WIDTH  word-aligned address {addr[31:2],2'b00}
o_mem_be  out  4  byte enables
o_mem_wdata  out  DATA_WIDTH  lane-steered store data
i_mem_rvalid  in  1  read data valid
i_mem_rdata  in  DATA_WIDTH  read data word

Behaviour:
- Reset (i_reset_n=0 at posedge): state IDLE; all outputs 0; captured fields cleared.
- Reset mid-transaction abandons the access: o_mem_req is 0 after that edge, and any later i_mem_rvalid is ignored.
- access = i_ie_valid & (i_ie_rd_en | i_ie_wr_en). If both rd_en and wr_en are set, the access is treated as a store.
- Fault conditions:
  - funct3 not in {000,001,010,100,101} for a load, or not in {000,001,010} for a store.
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]!=0.
- State IDLE:
  - access with no fault: latch addr/be/wdata/funct3/addr[1:0]/we, assert o_stall combinationally this cycle, go to REQ.
  - access with fault: o_fault=1 next cycle for one cycle; no bus activity; no stall.
  - i_mem_rvalid is ignored.
- State REQ:
  - o_mem_req=1, o_stall=1. o_mem_we/addr/be/wdata are registered and held stable until gnt.
  - req&gnt on a store: go to DONE.
  - req&gnt on a load: go to WAIT.
  - o_mem_req drops the cycle after gnt.
- State WAIT:
  - o_stall=1.
  - On i_mem_rvalid: register the extracted data into o_rd_data and go to DONE. The earliest rvalid is the cycle after gnt; rvalid in the gnt cycle is ignored.
- State DONE:
  - o_stall=0; o_rd_valid=1 for loads, 0 for stores; next state IDLE.
  - i_ie_* are ignored this cycle, because they still carry the completed instruction.
- o_rd_data holds its value until the next load completes.
- Store steering:
  - SB: be = 4'b0001 << addr[1:0]; wdata = byte replicated ×4.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011; wdata = halfword replicated ×2.
  - SW: be = 4'b1111; wdata unchanged.
- Load steering (loads drive o_mem_be = 4'b1111):
  - Select the byte at rdata[8*addr[1:0]+:8] or the halfword at rdata[16*addr[1]+:16].
  - LB/LH sign-extend to 32 bits; LBU/LHU zero-extend; LW passes the word.
- Minimum latency:
  - Store with gnt in the first REQ cycle: 3 cycles, IDLE→REQ→DONE.
  - Load: 4 cycles, IDLE→REQ→WAIT→DONE.
  - No upper bound; the unit waits indefinitely for gnt/rvalid.
- Only one access is outstanding at a time; back-to-back accesses are separated by the DONE and IDLE cycles.

Test Plan:
- Reset: assert i_reset_n=0 for 2 cycles with i_ie_valid=1 → o_stall, o_mem_req, o_rd_valid and o_fault are all 0.
- SB, addr=0x1003, wr_data=0xAABBCCDD, gnt immediate → o_mem_addr=0x1000, o_mem_be=4'b1000, o_mem_wdata=0xDDDDDDDD, o_mem_we=1, o_stall high 2 cycles then low in DONE, o_rd_valid=0.
- LB, addr=0x2001, rdata=0x12348056, gnt after 3 REQ cycles, rvalid 2 cycles later → req fields stable throughout, o_rd_data=0xFFFFFF80, o_rd_valid one-cycle pulse, o_stall=0 only in DONE.
- LHU, addr=0x2002, rdata=0x8001_7F00 → o_rd_data=0x00008001. LH at the same address → o_rd_data=0xFFFF8001.
- LW addr=0x3002 → o_fault pulse next cycle, no o_mem_req, no stall. Load with funct3=3'b011 → o_fault pulse.
- Load in WAIT, i_reset_n=0 for one cycle, then rvalid arrives → state IDLE, o_rd_valid stays 0, next load completes normally.

Source files
------------

// File: rtl/lsu_mem_stage.sv
// Memory-access stage load/store unit for the 5-stage RV32I core.
// Converts execute-stage load/store requests into single transactions on a
// req/gnt/rvalid bus. It steers store byte lanes and extends load data. It
// flags misaligned or illegal accesses, and it stalls the front of the pipe
// while an access is in flight.
module lsu_mem_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_ie_valid,
  input  logic                  i_ie_rd_en,
  input  logic                  i_ie_wr_en,
  input  logic [2:0]            i_ie_funct3,
  input  logic [ADDR_WIDTH-1:0] i_ie_addr,
  input  logic [DATA_WIDTH-1:0] i_ie_wr_data,
  output logic                  o_stall,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_valid,
  output logic                  o_fault,
  output logic                  o_mem_req,
  input  logic                  i_mem_gnt,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [3:0]            o_mem_be,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic                  i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_e;

  // RV32I funct3 encodings for loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_e                  state_q, state_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [3:0]              be_q, be_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [2:0]              funct3_q, funct3_d;
  logic [1:0]              off_q, off_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic                    fault_q, fault_d;

  logic                    access;
  logic                    is_store;
  logic                    bad_funct3;
  logic                    misaligned;
  logic [3:0]              st_be;
  logic [DATA_WIDTH-1:0]   st_wdata;
  logic [7:0]              ld_byte;
  logic [15:0]             ld_half;
  logic [DATA_WIDTH-1:0]   ld_ext;

  // A set wr_en wins, so an instruction with both enables is a store
  assign access   = i_ie_valid & (i_ie_rd_en | i_ie_wr_en);
  assign is_store = i_ie_wr_en;

  // Decode the incoming access: legality, alignment and store lane steering
  always_comb begin
    // NOTE: every signal gets a default before the case so that no path leaves it unassigned (no latch).
    bad_funct3 = 1'b1;
    misaligned = 1'b0;
    st_be      = 4'b1111;
    st_wdata   = i_ie_wr_data;
    if (is_store) begin
      bad_funct3 = !(i_ie_funct3 inside {F3_B, F3_H, F3_W});
    end else begin
      bad_funct3 = !(i_ie_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    end
    case (i_ie_funct3[1:0])
      2'b01:   misaligned = i_ie_addr[0];
      2'b10:   misaligned = (i_ie_addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
    case (i_ie_funct3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << i_ie_addr[1:0];
        st_wdata = {4{i_ie_wr_data[7:0]}};
      end
      2'b01: begin
        st_be    = i_ie_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{i_ie_wr_data[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = i_ie_wr_data;
      end
    endcase
  end

  // Pick the addressed byte/halfword from the returned word and extend it
  always_comb begin
    ld_byte = i_mem_rdata[{off_q, 3'b000} +: 8];
    ld_half = off_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    case (funct3_q)
      F3_B:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    ld_ext = {{16{ld_half[15]}}, ld_half};
      F3_BU:   ld_ext = {24'b0, ld_byte};
      F3_HU:   ld_ext = {16'b0, ld_half};
      default: ld_ext = i_mem_rdata;
    endcase
  end

  // Next-state logic and stall generation
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    funct3_d  = funct3_q;
    off_d     = off_q;
    rd_data_d = rd_data_q;
    fault_d   = 1'b0;
    o_stall   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Stall is combinational here, so it is gated by reset to keep all
        // outputs low while the pipeline is held in reset.
        if (i_reset_n && access) begin
          if (bad_funct3 || misaligned) begin
            fault_d = 1'b1;
          end else begin
            o_stall  = 1'b1;
            state_d  = S_REQ;
            we_d     = is_store;
            addr_d   = {i_ie_addr[ADDR_WIDTH-1:2], 2'b00};
            be_d     = is_store ? st_be : 4'b1111;
            wdata_d  = is_store ? st_wdata : '0;
            funct3_d = i_ie_funct3;
            off_d    = i_ie_addr[1:0];
          end
        end
      end
      S_REQ: begin
        o_stall = 1'b1;
        if (i_mem_gnt) begin
          state_d = we_q ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        o_stall = 1'b1;
        if (i_mem_rvalid) begin
          rd_data_d = ld_ext;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        // IE still holds the completed instruction; do not restart it
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and captured-field registers with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (!i_reset_n) begin
      state_q   <= S_IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= 4'b0000;
      wdata_q   <= '0;
      funct3_q  <= 3'b000;
      off_q     <= 2'b00;
      rd_data_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      funct3_q  <= funct3_d;
      off_q     <= off_d;
      rd_data_q <= rd_data_d;
      fault_q   <= fault_d;
    end
  end

  assign o_mem_req   = (state_q == S_REQ);
  assign o_mem_we    = we_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_be    = be_q;
  assign o_mem_wdata = wdata_q;
  assign o_rd_data   = rd_data_q;
  assign o_rd_valid  = (state_q == S_DONE) && !we_q;
  assign o_fault     = fault_q;

endmodule
